// File: rtl/alarm_mem_copy_master.sv
// ============================================================================
// alarm_mem_copy_master : Avalon-MM master that copies or fills word blocks
// Revision 1.0
// ============================================================================
`default_nettype none

module alarm_mem_copy_master #(
  parameter int ADDR_W       = 14,
  parameter int MEM_WORDS    = 12265,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_mode,
  input  logic [ADDR_W-1:0] cmd_src,
  input  logic [ADDR_W-1:0] cmd_dst,
  input  logic [ADDR_W:0]   cmd_len,
  input  logic [31:0]       cmd_pattern,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   words_done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_chipselect,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  localparam logic [2:0] c_IDLE  = 3'd0;
  localparam logic [2:0] c_CHECK = 3'd1;
  localparam logic [2:0] c_RD    = 3'd2;
  localparam logic [2:0] c_RWAIT = 3'd3;
  localparam logic [2:0] c_WR    = 3'd4;
  localparam logic [2:0] c_FIN   = 3'd5;

  localparam logic [1:0] c_COPY = 2'b00;
  localparam logic [1:0] c_INCR = 2'b10;
  localparam logic [1:0] c_RSVD = 2'b11;

  localparam logic [ADDR_W:0] c_MEM_WORDS = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [1:0]      c_LAT_LAST  = 2'(READ_LATENCY - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [31:0]       pat_q, pat_d;
  logic [ADDR_W:0]   words_done_q, words_done_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        lat_q, lat_d;
  logic              err_q, err_d;

  logic [ADDR_W:0]   w_dst_end;
  logic [ADDR_W:0]   w_src_end;
  logic              w_reject;
  logic [ADDR_W:0]   w_words_inc;
  logic [31:0]       w_fill_data;

  assign w_dst_end   = {1'b0, dst_q} + len_q;
  assign w_src_end   = {1'b0, src_q} + len_q;
  assign w_words_inc = words_done_q + 1'b1;
  assign w_fill_data = (mode_q == c_INCR) ? pat_q + 32'(words_done_q) : pat_q;

  // A forward copy whose destination starts inside the source window would
  // overwrite source words before they are read.
  assign w_reject = (mode_q == c_RSVD) ||
                    (w_dst_end > c_MEM_WORDS) ||
                    ((mode_q == c_COPY) &&
                     ((w_src_end > c_MEM_WORDS) ||
                      ((src_q < dst_q) && ({1'b0, dst_q} < w_src_end))));

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    src_d        = src_q;
    dst_d        = dst_q;
    len_d        = len_q;
    pat_d        = pat_q;
    words_done_d = words_done_q;
    rdata_d      = rdata_q;
    lat_d        = lat_q;
    err_d        = err_q;
    case (state_q)
      c_IDLE: begin
        if (cmd_valid) begin
          mode_d       = cmd_mode;
          src_d        = cmd_src;
          dst_d        = cmd_dst;
          len_d        = cmd_len;
          pat_d        = cmd_pattern;
          words_done_d = '0;
          err_d        = 1'b0;
          state_d      = c_CHECK;
        end
      end
      c_CHECK: begin
        if (w_reject) begin
          err_d   = 1'b1;
          state_d = c_FIN;
        end else if (len_q == '0) begin
          state_d = c_FIN;
        end else if (mode_q == c_COPY) begin
          state_d = c_RD;
        end else begin
          state_d = c_WR;
        end
      end
      c_RD: begin
        if (!avm_waitrequest) begin
          lat_d   = c_LAT_LAST;
          state_d = c_RWAIT;
        end
      end
      c_RWAIT: begin
        if (lat_q == 2'd0) begin
          rdata_d = avm_readdata;
          state_d = c_WR;
        end else begin
          lat_d = lat_q - 2'd1;
        end
      end
      c_WR: begin
        if (!avm_waitrequest) begin
          words_done_d = w_words_inc;
          src_d        = src_q + 1'b1;
          dst_d        = dst_q + 1'b1;
          if (w_words_inc == len_q)     state_d = c_FIN;
          else if (mode_q == c_COPY)    state_d = c_RD;
          else                          state_d = c_WR;
        end
      end
      c_FIN:   state_d = c_IDLE;
      default: state_d = c_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= c_IDLE;
      mode_q       <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      len_q        <= '0;
      pat_q        <= '0;
      words_done_q <= '0;
      rdata_q      <= '0;
      lat_q        <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      src_q        <= src_d;
      dst_q        <= dst_d;
      len_q        <= len_d;
      pat_q        <= pat_d;
      words_done_q <= words_done_d;
      rdata_q      <= rdata_d;
      lat_q        <= lat_d;
      err_q        <= err_d;
    end
  end

  assign cmd_ready      = (state_q == c_IDLE);
  assign busy           = (state_q != c_IDLE);
  assign done           = (state_q == c_FIN);
  assign err            = (state_q == c_FIN) && err_q;
  assign words_done     = words_done_q;
  assign avm_chipselect = (state_q == c_RD) || (state_q == c_WR);
  assign avm_write      = (state_q == c_WR);
  assign avm_byteenable = 4'hF;
  assign avm_address    = (state_q == c_RD) ? src_q :
                          (state_q == c_WR) ? dst_q : '0;
  assign avm_writedata  = (state_q != c_WR)  ? 32'd0 :
                          (mode_q == c_COPY) ? rdata_q : w_fill_data;

endmodule

`default_nettype wire
